// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped stream output port.
// Register offsets (DataAdr[3:2]), STATUS/CTRL bit positions and STATUS layout.
package mmio_pkg;

  localparam logic [1:0] MMIO_DATA   = 2'd0;
  localparam logic [1:0] MMIO_STATUS = 2'd1;
  localparam logic [1:0] MMIO_CTRL   = 2'd2;
  localparam logic [1:0] MMIO_OVFCNT = 2'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;

  typedef struct packed {
    logic [15:0] count;
    logic [12:0] rsvd;
    logic        ovf;
    logic        full;
    logic        empty;
  } mmio_status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush. Owns pointers and storage; head word is
// gated to zero when empty. Push while full is only taken with a same-cycle pop.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [DATA_W-1:0]        i_din,
  output logic [DATA_W-1:0]        o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic [CW-1:0]     r_count;
  logic              w_pop;
  logic              w_push;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = o_empty ? '0 : r_mem[r_rd];

  assign w_pop  = i_pop && !o_empty && !i_flush;
  assign w_push = i_push && (!o_full || w_pop) && !i_flush;

  // Storage write; contents intentionally survive reset and flush.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  // Pointer and occupancy update; flush behaves like a soft reset of pointers.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_stream_out.sv
// Memory-mapped stream output: DATA stores feed a FIFO drained over valid/ready.
// Optional dropped-push counter at offset 0xC is built when MMIO_OVF_COUNT_EN is defined.
module mmio_stream_out
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          DATA_W    = 8,
  parameter int          DEPTH     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       DataAdr,
  input  logic [31:0]       WriteData,
  input  logic              MemWrite,
  output logic [31:0]       ReadData,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]        w_off;
  logic              w_wr_data;
  logic              w_wr_ctrl;
  logic              w_flush;
  logic              w_clr;
  logic              w_pop;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [DATA_W-1:0] w_dout;
  logic [31:0]       w_data_rd;
  logic [31:0]       w_ovfcnt_rd;
  logic [2:0]        w_flags;
  mmio_status_t      w_status;
  logic              r_ovf;
  logic              w_unused;

  assign sel       = (DataAdr[31:4] == BASE_ADDR[31:4]);
  assign w_off     = DataAdr[3:2];
  assign w_wr_data = sel && MemWrite && (w_off == MMIO_DATA);
  assign w_wr_ctrl = sel && MemWrite && (w_off == MMIO_CTRL);
  assign w_flush   = w_wr_ctrl && WriteData[CTRL_FLUSH];
  assign w_clr     = w_wr_ctrl && WriteData[CTRL_CLR_OVF];
  assign w_pop     = out_valid && out_ready;
  // A push can only be refused when full and the head is not leaving this cycle.
  assign w_drop    = w_wr_data && w_full && !w_pop && !w_flush;

  // Byte-lane address bits and upper store bits are don't-care for this port.
  assign w_unused  = ^{DataAdr[1:0], WriteData};

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_wr_data),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (WriteData[DATA_W-1:0]),
    .o_dout  (w_dout),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_dout;

  // Sticky overflow flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)       r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
    else if (w_clr)  r_ovf <= 1'b0;
  end

`ifdef MMIO_OVF_COUNT_EN
  logic [15:0] r_ovfcnt;

  // Saturating count of dropped pushes; drop+clear leaves exactly one.
  always_ff @(posedge clk) begin
    if (reset) r_ovfcnt <= '0;
    else if (w_drop) begin
      if (w_clr)                     r_ovfcnt <= 16'd1;
      else if (r_ovfcnt != 16'hFFFF) r_ovfcnt <= r_ovfcnt + 16'd1;
    end else if (w_clr) r_ovfcnt <= '0;
  end

  assign w_ovfcnt_rd = {16'b0, r_ovfcnt};
`else
  assign w_ovfcnt_rd = '0;
`endif

  // STATUS assembly and zero-extension of the head word.
  always_comb begin
    w_flags           = '0;
    w_flags[ST_EMPTY] = w_empty;
    w_flags[ST_FULL]  = w_full;
    w_flags[ST_OVF]   = r_ovf;
    w_status          = '{count: 16'(w_count), rsvd: '0,
                          ovf: w_flags[ST_OVF], full: w_flags[ST_FULL],
                          empty: w_flags[ST_EMPTY]};
    w_data_rd               = '0;
    w_data_rd[DATA_W-1:0]   = w_dout;
  end

  // Read mux; anything outside the window reads zero.
  always_comb begin
    ReadData = '0;
    if (sel) begin
      case (w_off)
        MMIO_DATA:   ReadData = w_data_rd;
        MMIO_STATUS: ReadData = w_status;
        MMIO_OVFCNT: ReadData = w_ovfcnt_rd;
        default:     ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_stream_out.sv
// Bench for mmio_stream_out: register-read vector table plus hand sequences
// for overflow, drain, push-while-full, flush and reset mid-drain.
// The expected FIFO contents live in a queue; words are compared as the DUT pops them.
module tb_mmio_stream_out;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic        sel;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  int tests = 0;
  int fails = 0;

  logic [7:0] sb[$];
  logic       m_ovf;
  logic [15:0] m_cnt;

`ifdef MMIO_OVF_COUNT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  mmio_stream_out dut (
    .clk       (clk),
    .reset     (reset),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive at the negedge, check outputs mid-cycle,
  // advance the reference model with the edge semantics, then wait for the edge.
  task automatic step(input logic [31:0] adr, input logic [31:0] wd, input logic we,
                      input logic rdy, input logic rst,
                      input logic do_rd, input logic [31:0] exp_rd, input logic exp_sel);
    logic flush, clr, pushreq, pop, full, drop;
    logic [7:0] head;
    DataAdr = adr; WriteData = wd; MemWrite = we; out_ready = rdy; reset = rst;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
    chk("out_data", {24'b0, out_data}, {24'b0, (sb.size() != 0) ? sb[0] : 8'h00});
    if (do_rd) begin
      chk("ReadData", ReadData, exp_rd);
      chk("sel", {31'b0, sel}, {31'b0, exp_sel});
    end
    if (rst) begin
      sb.delete(); m_ovf = 1'b0; m_cnt = '0;
    end else begin
      flush   = (adr[31:4] == 28'h000_0040) && we && (adr[3:2] == 2'd2) && wd[0];
      clr     = (adr[31:4] == 28'h000_0040) && we && (adr[3:2] == 2'd2) && wd[1];
      pushreq = (adr[31:4] == 28'h000_0040) && we && (adr[3:2] == 2'd0);
      drop    = 1'b0;
      if (flush) sb.delete();
      else begin
        full = (sb.size() == 16);
        pop  = rdy && (sb.size() != 0);
        if (pop) begin
          head = sb.pop_front();
          chk("pop_word", {24'b0, out_data}, {24'b0, head});
        end
        if (pushreq) begin
          if (!full || pop) sb.push_back(wd[7:0]);
          else drop = 1'b1;
        end
      end
      if (drop) begin
        m_ovf = 1'b1;
        m_cnt = clr ? 16'd1 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1);
      end else if (clr) begin
        m_ovf = 1'b0; m_cnt = '0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp_rd);
    step(adr, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, exp_rd, 1'b1);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] wd, input logic rdy);
    step(adr, wd, 1'b1, rdy, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wd;
    logic        we;
    logic        rdy;
    logic [31:0] exp_rd;
    logic        exp_sel;
  } vec_t;

  vec_t vt[$];

  initial begin
    // Table: each row reads ReadData combinationally before its edge takes effect.
    vt.push_back('{32'h404, 32'h0,         1'b0, 1'b0, 32'h0000_0001, 1'b1});
    vt.push_back('{32'h400, 32'hA5,        1'b1, 1'b0, 32'h0000_0000, 1'b1});
    vt.push_back('{32'h404, 32'h0,         1'b0, 1'b0, 32'h0001_0000, 1'b1});
    vt.push_back('{32'h400, 32'h0,         1'b0, 1'b0, 32'h0000_00A5, 1'b1});
    vt.push_back('{32'h408, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b1});
    vt.push_back('{32'h40C, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b1});
    vt.push_back('{32'h500, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0});
    vt.push_back('{32'h3F0, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0});
    vt.push_back('{32'h403, 32'h1234_5677, 1'b1, 1'b0, 32'h0000_00A5, 1'b1});
    vt.push_back('{32'h405, 32'h0,         1'b0, 1'b0, 32'h0002_0000, 1'b1});
    vt.push_back('{32'h404, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0002_0000, 1'b1});
    vt.push_back('{32'h404, 32'h0,         1'b0, 1'b1, 32'h0002_0000, 1'b1});
    vt.push_back('{32'h400, 32'h0,         1'b0, 1'b0, 32'h0000_0077, 1'b1});
    vt.push_back('{32'h408, 32'h1,         1'b1, 1'b0, 32'h0000_0000, 1'b1});
    vt.push_back('{32'h404, 32'h0,         1'b0, 1'b0, 32'h0000_0001, 1'b1});

    m_ovf = 1'b0; m_cnt = '0;
    reset = 1'b1; DataAdr = '0; WriteData = '0; MemWrite = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vt[i])
      step(vt[i].adr, vt[i].wd, vt[i].we, vt[i].rdy, 1'b0, 1'b1, vt[i].exp_rd, vt[i].exp_sel);

    // Fill to 16, then a 17th store is dropped and sets ovf.
    for (int i = 0; i < 16; i++) wr(32'h400, i, 1'b0);
    wr(32'h400, 32'hFF, 1'b0);
    rd(32'h404, 32'h0010_0006);
    rd(32'h40C, HAS_CNT ? 32'h1 : 32'h0);
    chk("model_ovfcnt", {16'b0, m_cnt}, 32'h1);

    // Drain all sixteen, one per cycle, in order.
    for (int i = 0; i < 16; i++) step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    rd(32'h404, 32'h0000_0005);
    wr(32'h408, 32'h2, 1'b0);
    rd(32'h404, 32'h0000_0001);
    rd(32'h40C, 32'h0);

    // Push while full with a same-cycle pop: accepted, ovf untouched.
    for (int i = 0; i < 16; i++) wr(32'h400, 32'h10 + i, 1'b0);
    wr(32'h400, 32'h3C, 1'b1);
    rd(32'h404, 32'h0010_0002);
    for (int i = 0; i < 16; i++) step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    rd(32'h404, 32'h0000_0001);

    // Flush + clear-ovf with ready high: no pop, FIFO empty next cycle.
    for (int i = 0; i < 5; i++) wr(32'h400, 32'h50 + i, 1'b0);
    rd(32'h404, 32'h0005_0000);
    wr(32'h408, 32'h3, 1'b1);
    rd(32'h404, 32'h0000_0001);
    rd(32'h400, 32'h0);

    // Reset while draining.
    for (int i = 0; i < 8; i++) wr(32'h400, 32'h80 + i, 1'b0);
    for (int i = 0; i < 3; i++) step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    rd(32'h404, 32'h0000_0001);
    step(32'h500, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
